// File: rtl/code_word_to_bcd_bin.sv
// code_word_to_bcd_bin
//   Sequential decoder from the 10-state hgfe digit code to packed BCD and
//   binary. A word of DIGITS code digits is accepted in IDLE, decoded one
//   digit per clock (most significant first), then held in DONE until the
//   consumer takes it.
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready only in IDLE)
//   in_code             DIGITS x 4-bit code digits, MS digit in the top nibble
//   out_valid/out_ready output handshake
//   out_bcd             packed BCD, same digit order as in_code
//   out_bin             binary value of the decoded digits, mod 2^BIN_W
//   out_err             set when any digit held an invalid code
//   err_mask            bit i set when digit i held an invalid code
module code_word_to_bcd_bin #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] in_code,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] out_bcd,
  output logic [BIN_W-1:0]    out_bin,
  output logic                out_err,
  output logic [DIGITS-1:0]   err_mask
);

  localparam int unsigned CODE_W = 4 * DIGITS;
  localparam int unsigned CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CODE_W-1:0]   r_shift;
  logic [CODE_W-1:0]   r_bcd;
  logic [BIN_W-1:0]    r_bin;
  logic [DIGITS-1:0]   r_mask;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_in_ready;
  logic                r_out_valid;

  logic [3:0]          w_top;
  logic [3:0]          w_digit;
  logic                w_inv;
  logic                w_accept;
  logic                w_last;
  logic                w_in_ready_nxt;
  logic                w_out_valid_nxt;

  assign w_top    = r_shift[CODE_W-1 -: 4];
  assign w_accept = (r_state == S_IDLE) && in_valid && r_in_ready;
  assign w_last   = (r_cnt == CNT_W'(DIGITS - 1));

  // Code table lookup; invalid codes decode as 0 and raise w_inv
  always_comb begin
    w_digit = 4'd0;
    w_inv   = 1'b0;
    case (w_top)
      4'b0000: w_digit = 4'd0;
      4'b0001: w_digit = 4'd1;
      4'b0011: w_digit = 4'd2;
      4'b0100: w_digit = 4'd3;
      4'b0101: w_digit = 4'd4;
      4'b0111: w_digit = 4'd5;
      4'b1001: w_digit = 4'd6;
      4'b1011: w_digit = 4'd7;
      4'b1100: w_digit = 4'd8;
      4'b1101: w_digit = 4'd9;
      default: w_inv   = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept)  w_state_nxt = S_CONV;
      S_CONV:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default:                w_state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs are looked up from the next state so they register
  // in step with the state itself
  always_comb begin
    w_in_ready_nxt  = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (w_state_nxt)
      S_IDLE:  w_in_ready_nxt  = 1'b1;
      S_DONE:  w_out_valid_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Datapath: capture on accept, one digit per clock while converting.
  // The mask shifts in from the LSB, so the MS digit's flag ends at bit DIGITS-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_mask  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shift <= in_code;
      r_bcd   <= '0;
      r_bin   <= '0;
      r_mask  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == S_CONV) begin
      r_shift <= r_shift << 4;
      r_bcd   <= (r_bcd << 4) | CODE_W'(w_digit);
      r_bin   <= BIN_W'(r_bin * BIN_W'(10)) + BIN_W'(w_digit);
      r_mask  <= (r_mask << 1) | DIGITS'(w_inv);
      r_err   <= r_err | w_inv;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_bcd   = r_bcd;
  assign out_bin   = r_bin;
  assign out_err   = r_err;
  assign err_mask  = r_mask;

endmodule
